// File: rtl/fir_filter.sv
// fir_filter: 33-tap symmetric low-pass FIR, time-shared pre-add/MAC, 18-clock latency.
// Define FIR_VALID_EN to add the oFirValid output pulse.
module fir_filter (
  input  logic              iClk_12MHz,
  input  logic              iRsn,
  input  logic signed [2:0] iFirIn,
  input  logic              iEnSample_600kHz,
  output logic signed [15:0] oFirOut
`ifdef FIR_VALID_EN
  ,
  output logic              oFirValid
`endif
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  // Left half of the symmetric impulse response; entry 16 is the center tap.
  localparam logic signed [10:0] H [0:16] = '{
    11'sd0, -11'sd1, 11'sd0, 11'sd3, 11'sd0, -11'sd8, 11'sd0, 11'sd17, 11'sd0,
    -11'sd34, 11'sd0, 11'sd62, 11'sd0, -11'sd116, 11'sd0, 11'sd325, 11'sd512
  };
  state_t state, state_n;
  logic signed [2:0]  x [0:32];
  logic signed [15:0] acc;
  logic [4:0]         cnt;
  logic [5:0]         lo, hi;
  logic signed [3:0]  pre;
  logic signed [10:0] coef;
  logic signed [14:0] prod;
  logic               last;
  always_comb begin
    lo   = {1'b0, cnt};
    hi   = 6'd32 - lo;
    last = cnt == 5'd16;
    pre  = last ? {x[lo][2], x[lo]} : {x[lo][2], x[lo]} + {x[hi][2], x[hi]};
    coef = (cnt <= 5'd16) ? H[cnt] : 11'sd0;
    prod = pre * coef;
  end
  // A strobe always wins: it restarts the computation from any state.
  always_comb begin
    state_n = iEnSample_600kHz ? MAC :
              (state == MAC && last) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge iClk_12MHz or posedge iRsn)
    if (iRsn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge iClk_12MHz or posedge iRsn)
    if (iRsn) begin
      for (int k = 0; k <= 32; k++) x[k] <= '0;
      acc     <= '0;
      cnt     <= '0;
      oFirOut <= '0;
    end else if (iEnSample_600kHz) begin
      for (int k = 32; k > 0; k--) x[k] <= x[k-1];
      x[0] <= iFirIn;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == MAC) begin
      acc <= acc + {prod[14], prod};
      cnt <= cnt + 5'd1;
    end else if (state == DONE) begin
      oFirOut <= acc;
    end
`ifdef FIR_VALID_EN
  always_ff @(posedge iClk_12MHz or posedge iRsn)
    if (iRsn) oFirValid <= 1'b0;
    else oFirValid <= state == DONE && !iEnSample_600kHz;
`endif
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed scoreboard bench for fir_filter against a direct 33-tap convolution model.
module tb_fir_filter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic signed [2:0]  din = '0;
  logic signed [15:0] dout;
`ifdef FIR_VALID_EN
  logic valid;
`endif
  int compared = 0, mismatched = 0;
  int mx [0:32];
  int half [0:16] = '{0, -1, 0, 3, 0, -8, 0, 17, 0, -34, 0, 62, 0, -116, 0, 325, 512};
  logic signed [15:0] last = '0;
  logic signed [15:0] sb [$];
  always #5 clk = ~clk;
  fir_filter dut (
    .iClk_12MHz(clk),
    .iRsn(rst),
    .iFirIn(din),
    .iEnSample_600kHz(en),
    .oFirOut(dout)
`ifdef FIR_VALID_EN
    ,
    .oFirValid(valid)
`endif
  );
  task automatic check(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_valid(input string tag, input logic exp);
`ifdef FIR_VALID_EN
    compared++;
    assert (valid === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, valid, exp);
    end
`endif
  endtask
  function automatic int model_y();
    int y = 0;
    for (int k = 0; k <= 32; k++) y += half[k <= 16 ? k : 32 - k] * mx[k];
    return y;
  endfunction
  task automatic clear_model();
    for (int k = 0; k <= 32; k++) mx[k] = 0;
  endtask
  // Strobe one sample; on return we sit #1 after the capturing edge T0.
  task automatic strobe(input logic signed [2:0] s, input bit push);
    @(posedge clk); #1;
    en = 1'b1;
    din = s;
    for (int k = 32; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = int'(s);
    if (push) sb.push_back(16'(model_y()));
    @(posedge clk); #1;
    en = 1'b0;
    din = 3'($urandom);
  endtask
  task automatic finish_out(input string tag);
    logic signed [15:0] e;
    repeat (17) @(posedge clk);
    #1;
    check({tag, "_hold"}, dout, last);
    check_valid({tag, "_valid_lo"}, 1'b0);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed %0d expected scoreboard entry, none queued", tag, dout);
    end else begin
      e = sb.pop_front();
      check(tag, dout, e);
      last = e;
    end
    check_valid({tag, "_valid_hi"}, 1'b1);
  endtask
  initial begin
    clear_model();
    repeat (2) begin
      @(posedge clk); #1;
      en = 1'($urandom);
      din = 3'($urandom);
    end
    check("reset_out", dout, 16'sd0);
    check_valid("reset_valid", 1'b0);
    rst = 1'b0;
    en = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("idle_out", dout, 16'sd0);
    for (int k = 0; k < 128; k++) begin
      strobe((k % 64 == 0) ? 3'sd1 : 3'sd0, 1'b1);
      finish_out("pos_imp");
      if (k == 16 || k == 80) check("pos_center", dout, 16'sd512);
      if (k == 40) check("pos_tail", dout, 16'sd0);
    end
    for (int k = 0; k < 34; k++) begin
      strobe((k == 0) ? -3'sd4 : 3'sd0, 1'b1);
      finish_out("neg_imp");
      if (k == 15) check("neg_k15", dout, 16'shFAEC);
      if (k == 16) check("neg_center", dout, 16'shF800);
    end
    for (int k = 0; k < 40; k++) begin
      strobe(3'sd3, 1'b1);
      finish_out("dc_pos");
    end
    check("dc_pos_settle", dout, 16'sh0BD0);
    for (int k = 0; k < 40; k++) begin
      strobe(-3'sd4, 1'b1);
      finish_out("dc_neg");
    end
    check("dc_neg_settle", dout, 16'shF040);
    strobe(3'sd2, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("early_hold", dout, last);
    strobe(-3'sd1, 1'b1);
    finish_out("early");
    strobe(3'sd3, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_async", dout, 16'sd0);
    check_valid("midrst_valid", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    last = '0;
    check("midrst_released", dout, 16'sd0);
    for (int k = 0; k < 18; k++) begin
      strobe((k == 0) ? 3'sd1 : 3'sd0, 1'b1);
      finish_out("post_rst_imp");
      if (k == 15) check("post_rst_k15", dout, 16'sd325);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
